// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline widths and the EX/MEM entry layout used by the EX/MEM stage and its bench.
package cpu_pipe_pkg;

  localparam int CTRL_W       = 25;
  localparam int DATA_W       = 32;
  localparam int REG_AW       = 5;
  localparam int REGWRITE_BIT = 0;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pb;
    logic [REG_AW-1:0] dest;
  } ex_mem_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready pipeline register: one output register plus one skid entry,
// with a registered in_ready so ready never ripples combinationally back upstream.
module pipe_skid_buf #(
  parameter int           W        = 8,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         ld, acc;

  // Bits in CLR_MASK are zeroed whenever the output register empties.
  always_comb begin
    ld           = !out_valid_q || out_ready;
    acc          = in_valid && !skid_valid_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_data_d   = out_data_q & ~CLR_MASK;
    end else if (ld) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q & ~CLR_MASK;
      end
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: skid-buffered handshake, flush, bubble ctrl zeroing,
// forwarding qualifier for the hazard unit and a saturating MEM-stall counter.
module ex_mem_pipe_reg #(
  parameter int CTRL_W       = cpu_pipe_pkg::CTRL_W,
  parameter int DATA_W       = cpu_pipe_pkg::DATA_W,
  parameter int REG_AW       = cpu_pipe_pkg::REG_AW,
  parameter int REGWRITE_BIT = cpu_pipe_pkg::REGWRITE_BIT,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      ctrl_in,
  input  logic [DATA_W-1:0]      alu_result_in,
  input  logic [DATA_W-1:0]      pb_in,
  input  logic [REG_AW-1:0]      dest_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      ctrl_out,
  output logic [DATA_W-1:0]      alu_result_out,
  output logic [DATA_W-1:0]      pb_out,
  output logic [REG_AW-1:0]      dest_out,
  output logic                   fwd_valid,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int ENTRY_W = CTRL_W + 2 * DATA_W + REG_AW;
  // Only the control field is cleared on bubbles; data fields may keep stale values.
  localparam logic [ENTRY_W-1:0] CTRL_MASK = {{CTRL_W{1'b1}}, {(2 * DATA_W + REG_AW){1'b0}}};

  logic [ENTRY_W-1:0]     in_entry, out_entry;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign in_entry = {ctrl_in, alu_result_in, pb_in, dest_in};

  pipe_skid_buf #(
    .W        (ENTRY_W),
    .CLR_MASK (CTRL_MASK)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  assign {ctrl_out, alu_result_out, pb_out, dest_out} = out_entry;

  assign fwd_valid = out_valid && ctrl_out[REGWRITE_BIT] && (dest_out != '0);

  always_comb begin
    stall_d = stall_q;
    if (!flush && out_valid && !out_ready && (stall_q != '1))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: scoreboard queue of accepted entries checked in order
// as MEM drains them, plus direct checks of reset, backpressure, flush, forwarding and saturation.
`timescale 1ns/1ps
module tb_ex_mem_pipe_reg;

  localparam int CtrlW  = cpu_pipe_pkg::CTRL_W;
  localparam int DataW  = cpu_pipe_pkg::DATA_W;
  localparam int RegAw  = cpu_pipe_pkg::REG_AW;
  localparam int StallW = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              inValid;
  logic              inReady;
  logic [CtrlW-1:0]  ctrlIn;
  logic [DataW-1:0]  aluIn;
  logic [DataW-1:0]  pbIn;
  logic [RegAw-1:0]  destIn;
  logic              outValid;
  logic              outReady;
  logic [CtrlW-1:0]  ctrlOut;
  logic [DataW-1:0]  aluOut;
  logic [DataW-1:0]  pbOut;
  logic [RegAw-1:0]  destOut;
  logic              fwdValid;
  logic [StallW-1:0] stallCycles;

  cpu_pipe_pkg::ex_mem_entry_t sb[$];
  int passCount  = 0;
  int checkCount = 0;

  ex_mem_pipe_reg #(.STALL_CNT_W(StallW)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (inValid),
    .in_ready       (inReady),
    .ctrl_in        (ctrlIn),
    .alu_result_in  (aluIn),
    .pb_in          (pbIn),
    .dest_in        (destIn),
    .out_valid      (outValid),
    .out_ready      (outReady),
    .ctrl_out       (ctrlOut),
    .alu_result_out (aluOut),
    .pb_out         (pbOut),
    .dest_out       (destOut),
    .fwd_valid      (fwdValid),
    .stall_cycles   (stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic applyStimulus(input logic v, input logic [DataW-1:0] alu,
                               input logic [CtrlW-1:0] ctrl, input logic [RegAw-1:0] dest);
    inValid = v;
    aluIn   = alu;
    pbIn    = alu ^ 32'hA5A5_0000;
    ctrlIn  = ctrl;
    destIn  = dest;
  endtask

  // One clock: sample at negedge (scoreboard pop/push), then return 1 time unit after posedge.
  task automatic tick();
    cpu_pipe_pkg::ex_mem_entry_t expE;
    cpu_pipe_pkg::ex_mem_entry_t curE;
    @(negedge clk);
    if (outValid && outReady && !flush) begin
      if (sb.size() == 0) checkOutput("sb_unexpected_out", outValid, 1'b0);
      else begin
        expE = sb.pop_front();
        checkOutput("sb_entry", {ctrlOut, aluOut, pbOut, destOut}, expE);
      end
    end
    if (!outValid) checkOutput("ctrl_zero_bubble", ctrlOut, '0);
    curE = '{ctrl: ctrlIn, alu_result: aluIn, pb: pbIn, dest: destIn};
    if (flush) sb.delete();
    else if (inValid && inReady) sb.push_back(curE);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    outReady = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_out_valid", outValid, 1'b0);
    checkOutput("reset_in_ready", inReady, 1'b1);
    checkOutput("reset_ctrl", ctrlOut, '0);
    checkOutput("reset_alu", aluOut, '0);
    checkOutput("reset_stall", stallCycles, '0);

    $display("[TB] streaming 8 entries");
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h10 + i, 25'h1, RegAw'(i + 1));
      tick();
      checkOutput("stream_valid", outValid, 1'b1);
      checkOutput("stream_latency_alu", aluOut, 32'h10 + i);
      checkOutput("stream_in_ready", inReady, 1'b1);
    end
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    checkOutput("stream_empty_valid", outValid, 1'b0);
    checkOutput("stream_sb_drained", sb.size(), 0);
    checkOutput("stream_no_stall", stallCycles, '0);

    $display("[TB] backpressure");
    outReady = 1'b0;
    applyStimulus(1'b1, 32'hA, 25'h3, 5'd1);
    tick();
    applyStimulus(1'b1, 32'hB, 25'h5, 5'd2);
    tick();
    checkOutput("bp_in_ready_low", inReady, 1'b0);
    applyStimulus(1'b1, 32'hC, 25'h9, 5'd3);
    tick();
    tick();
    checkOutput("bp_hold_alu", aluOut, 32'hA);
    checkOutput("bp_hold_in_ready", inReady, 1'b0);
    checkOutput("bp_stall_3", stallCycles, 4'd3);
    outReady = 1'b1;
    tick();
    checkOutput("bp_skid_next", aluOut, 32'hB);
    checkOutput("bp_in_ready_back", inReady, 1'b1);
    tick();
    checkOutput("bp_c_next", aluOut, 32'hC);
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    checkOutput("bp_sb_drained", sb.size(), 0);
    checkOutput("bp_stall_kept", stallCycles, 4'd3);

    $display("[TB] flush with skid full");
    outReady = 1'b0;
    applyStimulus(1'b1, 32'hD0, 25'h1, 5'd4);
    tick();
    applyStimulus(1'b1, 32'hE0, 25'h1, 5'd5);
    tick();
    applyStimulus(1'b1, 32'hF0, 25'h1, 5'd6);
    tick();
    checkOutput("flush_pre_stall", stallCycles, 4'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_out_valid", outValid, 1'b0);
    checkOutput("flush_ctrl", ctrlOut, '0);
    checkOutput("flush_in_ready", inReady, 1'b1);
    checkOutput("flush_fwd", fwdValid, 1'b0);
    checkOutput("flush_stall_unchanged", stallCycles, 4'd5);
    applyStimulus(1'b0, '0, '0, '0);
    outReady = 1'b1;
    tick();
    checkOutput("flush_stays_empty", outValid, 1'b0);
    applyStimulus(1'b1, 32'hF1, 25'h1, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("flush_discard_incoming", outValid, 1'b0);
    tick();
    checkOutput("flush_sb_empty", sb.size(), 0);

    $display("[TB] forwarding qualifier");
    applyStimulus(1'b1, 32'h55, 25'h1, 5'd5);
    tick();
    checkOutput("fwd_dest5", fwdValid, 1'b1);
    applyStimulus(1'b1, 32'h56, 25'h1, 5'd0);
    tick();
    checkOutput("fwd_dest0", fwdValid, 1'b0);
    applyStimulus(1'b1, 32'h57, 25'h1FF_FFFE, 5'd7);
    tick();
    checkOutput("fwd_no_regwrite", fwdValid, 1'b0);
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    checkOutput("fwd_bubble", fwdValid, 1'b0);

    $display("[TB] async reset mid-stream");
    outReady = 1'b0;
    applyStimulus(1'b1, 32'h60, 25'h1, 5'd3);
    tick();
    applyStimulus(1'b1, 32'h61, 25'h1, 5'd4);
    tick();
    checkOutput("mid_pre_valid", outValid, 1'b1);
    checkOutput("mid_pre_in_ready", inReady, 1'b0);
    applyStimulus(1'b0, '0, '0, '0);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", outValid, 1'b0);
    checkOutput("mid_rst_ctrl", ctrlOut, '0);
    checkOutput("mid_rst_alu", aluOut, '0);
    checkOutput("mid_rst_fwd", fwdValid, 1'b0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("mid_rel_in_ready", inReady, 1'b1);
    checkOutput("mid_rel_stall", stallCycles, '0);

    $display("[TB] stall counter saturation");
    applyStimulus(1'b1, 32'h70, 25'h1, 5'd6);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) checkOutput("sat_count_10", stallCycles, 4'd10);
      if (i == 15) checkOutput("sat_count_15", stallCycles, 4'd15);
    end
    checkOutput("sat_hold_15", stallCycles, 4'd15);
    checkOutput("sat_held_alu", aluOut, 32'h70);
    outReady = 1'b1;
    tick();
    tick();
    checkOutput("sat_sb_drained", sb.size(), 0);
    checkOutput("sat_final_stall", stallCycles, 4'd15);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
